// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for simple_cpu and its instruction sequencer.
// Holds the opcode enum, funct constants, field bit positions and the NOP word.
package cpu_isa_pkg;

    localparam int INSTR_WIDTH = 20;

    // Opcode field, instruction bits [19:18]
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_RTYPE = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_e;

    // Funct field values, instruction bits [3:0]
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;

    // Field bit positions, MSB first
    localparam int OP_MSB    = 19;
    localparam int OP_LSB    = 18;
    localparam int X1_MSB    = 17;
    localparam int X1_LSB    = 16;
    localparam int X2_MSB    = 15;
    localparam int X2_LSB    = 14;
    localparam int X3_MSB    = 13;
    localparam int X3_LSB    = 12;
    localparam int IMM_MSB   = 11;
    localparam int IMM_LSB   = 4;
    localparam int FUNCT_MSB = 3;
    localparam int FUNCT_LSB = 0;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 20'h00000;

    // Extract the opcode of an instruction word
    function automatic op_e get_op(input logic [INSTR_WIDTH-1:0] instr);
        return op_e'(instr[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem: program store for instr_sequencer.
// 2**ADDR_BITS words, synchronous write, asynchronous (combinational) read.
module prog_mem #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Write port: the store is loaded one word per enabled clock
    // NOTE: the array has no reset branch on purpose; the program must survive rst,
    // and a reset on a memory array also prevents mapping it to RAM.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues a stored program to simple_cpu, holding each word
// for HOLD_CYCLES clocks. IDLE/RUN/DONE FSM with registered outputs.
// Optional macro SEQ_LOOP_EN: after the last word wrap to address 0 and keep
// running until stop or rst instead of entering DONE.
module instr_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic [ADDR_BITS-1:0]   last_addr,
    input  logic                   start,
    input  logic                   stop,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(INSTR_NOP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                 state;
    logic [CNT_W-1:0]       hold_cnt;
    logic [ADDR_BITS-1:0]   last_q;
    logic                   stop_seen;

    logic [ADDR_BITS-1:0]   next_pc;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic                   mem_wen;
    logic                   hold_end;
    logic                   stop_hit;
    logic                   launch;

    // Writes are blocked while a program is being issued
    assign mem_wen  = prog_wen && (state != S_RUN);
    assign hold_end = (hold_cnt == HOLD_LAST);
    assign stop_hit = stop_seen || stop;
    assign launch   = start && !prog_wen;

    // Next address to issue; in loop mode the last word is followed by word 0
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        next_pc = pc + ADDR_BITS'(1);
`ifdef SEQ_LOOP_EN
        if (pc == last_q) begin
            next_pc = '0;
        end
`endif
    end

    // Outside RUN the only word ever fetched is the first one
    assign rd_addr = (state == S_RUN) ? next_pc : '0;

    prog_mem #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_prog_mem (
        .clk   (clk),
        .wen   (mem_wen),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Sequencer FSM: hold counter, sticky stop, pc and registered outputs
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            last_q      <= '0;
            stop_seen   <= 1'b0;
            instruction <= NOP_WORD;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state       <= S_RUN;
                        last_q      <= last_addr;
                        instruction <= rd_data;
                        pc          <= '0;
                        hold_cnt    <= '0;
                        stop_seen   <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!hold_end) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        if (stop) begin
                            stop_seen <= 1'b1;
                        end
                    end else if (stop_hit) begin
                        state       <= S_IDLE;
                        instruction <= NOP_WORD;
                        pc          <= '0;
                        hold_cnt    <= '0;
                        stop_seen   <= 1'b0;
                        busy        <= 1'b0;
                    end
`ifndef SEQ_LOOP_EN
                    else if (pc == last_q) begin
                        state       <= S_DONE;
                        instruction <= NOP_WORD;
                        pc          <= '0;
                        hold_cnt    <= '0;
                        stop_seen   <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
`endif
                    else begin
                        pc          <= next_pc;
                        instruction <= rd_data;
                        hold_cnt    <= '0;
                        stop_seen   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// u_dut uses HOLD_CYCLES=4; u_dut1 uses HOLD_CYCLES=1 for the full-store run.
// Honors SEQ_LOOP_EN the same way as the RTL.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_wen = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic [4:0]  last_addr = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] instruction;
    logic [4:0]  pc;
    logic        busy;
    logic        done;

    logic [4:0]  last_addr1 = '0;
    logic        start1 = 1'b0;
    logic        stop1 = 1'b0;
    logic [19:0] instruction1;
    logic [4:0]  pc1;
    logic        busy1;
    logic        done1;

    int checks = 0;
    int errors = 0;

    logic [19:0] w [3];

    always #5 clk = ~clk;

    instr_sequencer #(.INSTR_WIDTH(20), .ADDR_BITS(5), .HOLD_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .prog_wen(prog_wen), .prog_addr(prog_addr),
        .prog_data(prog_data), .last_addr(last_addr), .start(start), .stop(stop),
        .instruction(instruction), .pc(pc), .busy(busy), .done(done)
    );

    instr_sequencer #(.INSTR_WIDTH(20), .ADDR_BITS(5), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .prog_wen(prog_wen), .prog_addr(prog_addr),
        .prog_data(prog_data), .last_addr(last_addr1), .start(start1), .stop(stop1),
        .instruction(instruction1), .pc(pc1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_word(input logic [4:0] a, input logic [19:0] d);
        prog_addr = a;
        prog_data = d;
        prog_wen  = 1'b1;
        @(negedge clk);
        prog_wen  = 1'b0;
    endtask

    // After return the current negedge is cycle 0 of the run
    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bring u_dut back to a non-busy state within a bounded number of cycles
    task automatic end_run();
`ifdef SEQ_LOOP_EN
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`endif
        for (int i = 0; i < 40 && busy; i++) begin
            @(negedge clk);
        end
        check("run_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        w[0] = 20'h47000;
        w[1] = 20'h53000;
        w[2] = 20'h72001;

        // 1. reset for two clocks, then idle with no start
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("t1_instr", 32'(instruction), 32'h0);
            check("t1_pc",    32'(pc),          32'd0);
            check("t1_busy",  32'(busy),        32'd0);
            check("t1_done",  32'(done),        32'd0);
            @(negedge clk);
        end

        // 2. three-word program, each word held four clocks
        for (int i = 0; i < 3; i++) write_word(5'(i), w[i]);
        last_addr = 5'd2;
        start_run();
        for (int k = 0; k < 12; k++) begin
            check("t2_instr", 32'(instruction), 32'(w[k/4]));
            check("t2_pc",    32'(pc),          32'(k/4));
            check("t2_busy",  32'(busy),        32'd1);
            @(negedge clk);
        end
`ifdef SEQ_LOOP_EN
        check("t2_wrap_instr", 32'(instruction), 32'(w[0]));
        check("t2_wrap_pc",    32'(pc),          32'd0);
        check("t2_wrap_busy",  32'(busy),        32'd1);
        end_run();
`else
        check("t2_done",       32'(done),        32'd1);
        check("t2_done_instr", 32'(instruction), 32'h0);
        check("t2_done_busy",  32'(busy),        32'd0);
        check("t2_done_pc",    32'(pc),          32'd0);
`endif

        // 3. stop on the second clock of word 1: word 1 finishes, word 2 never issued
        start_run();
        for (int k = 0; k < 8; k++) begin
            check("t3_instr", 32'(instruction), 32'(w[k/4]));
            stop = (k == 5);
            @(negedge clk);
        end
        stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("t3_idle_instr", 32'(instruction), 32'h0);
            check("t3_idle_busy",  32'(busy),        32'd0);
            check("t3_idle_done",  32'(done),        32'd0);
            @(negedge clk);
        end

        // 4. reset on the sixth clock of a run aborts at once, store retained
        start_run();
        for (int k = 0; k < 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_instr", 32'(instruction), 32'h0);
        check("t4_rst_busy",  32'(busy),        32'd0);
        check("t4_rst_pc",    32'(pc),          32'd0);
        check("t4_rst_done",  32'(done),        32'd0);
        start_run();
        check("t4_re_instr", 32'(instruction), 32'h47000);
        check("t4_re_pc",    32'(pc),          32'd0);
        check("t4_re_busy",  32'(busy),        32'd1);
        end_run();

        // 5a. writes during RUN are dropped
        start_run();
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                prog_addr = 5'd1;
                prog_data = 20'hFFFFF;
                prog_wen  = 1'b1;
            end else begin
                prog_wen  = 1'b0;
            end
            if (k >= 4) check("t5_word1", 32'(instruction), 32'h53000);
            @(negedge clk);
        end
        end_run();

        // 5b. write together with start in IDLE: write lands, no run begins
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prog_addr = 5'd1;
        prog_data = 20'h12345;
        prog_wen  = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        prog_wen  = 1'b0;
        start     = 1'b0;
        check("t5_ws_busy",  32'(busy),        32'd0);
        check("t5_ws_instr", 32'(instruction), 32'h0);
        check("t5_ws_done",  32'(done),        32'd0);
        @(negedge clk);
        check("t5_ws_busy2", 32'(busy),        32'd0);
        start_run();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) check("t5_new_w0", 32'(instruction), 32'h47000);
            if (k == 4) check("t5_new_w1", 32'(instruction), 32'h12345);
            @(negedge clk);
        end
        end_run();

        // 6. full 32-word store with HOLD_CYCLES=1
        for (int i = 0; i < 32; i++) write_word(5'(i), 20'hA0000 | 20'(i));
        last_addr1 = 5'd31;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("t6_pc",    32'(pc1),          32'(k));
            check("t6_instr", 32'(instruction1), 32'h000A0000 | 32'(k));
            check("t6_busy",  32'(busy1),        32'd1);
            @(negedge clk);
        end
`ifdef SEQ_LOOP_EN
        check("t6_wrap_pc",    32'(pc1),          32'd0);
        check("t6_wrap_busy",  32'(busy1),        32'd1);
        check("t6_wrap_instr", 32'(instruction1), 32'hA0000);
        stop1 = 1'b1;
        @(negedge clk);
        stop1 = 1'b0;
        for (int i = 0; i < 10 && busy1; i++) @(negedge clk);
        check("t6_stop_busy", 32'(busy1), 32'd0);
`else
        check("t6_done",       32'(done1),        32'd1);
        check("t6_done_busy",  32'(busy1),        32'd0);
        check("t6_done_instr", 32'(instruction1), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
